// File: rtl/except_ctrl_pkg.sv
// Shared exception codes, flag bit indices, FSM states and the priority encoder.
// Pure definitions; no clocked logic.
package except_ctrl_pkg;

    localparam logic [31:0] EXC_INT    = 32'h01;
    localparam logic [31:0] EXC_ADEL_I = 32'h10;
    localparam logic [31:0] EXC_RI     = 32'h0a;
    localparam logic [31:0] EXC_SYS    = 32'h08;
    localparam logic [31:0] EXC_BP     = 32'h0f;
    localparam logic [31:0] EXC_TR     = 32'h0d;
    localparam logic [31:0] EXC_OV     = 32'h0c;
    localparam logic [31:0] EXC_ADEL_D = 32'h11;
    localparam logic [31:0] EXC_ADES   = 32'h12;
    localparam logic [31:0] EXC_ERET   = 32'h0e;

    localparam int FLG_ADEL_I = 0;
    localparam int FLG_RI     = 1;
    localparam int FLG_SYS    = 2;
    localparam int FLG_BP     = 3;
    localparam int FLG_TR     = 4;
    localparam int FLG_OV     = 5;
    localparam int FLG_ADEL_D = 6;
    localparam int FLG_ADES   = 7;
    localparam int FLG_ERET   = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    // Highest-priority source wins; zero means nothing to report.
    function automatic logic [31:0] exc_code(input logic intr, input logic [8:0] flags);
        logic [31:0] c;
        c = 32'h0;
        if (intr)                    c = EXC_INT;
        else if (flags[FLG_ADEL_I])  c = EXC_ADEL_I;
        else if (flags[FLG_RI])      c = EXC_RI;
        else if (flags[FLG_SYS])     c = EXC_SYS;
        else if (flags[FLG_BP])      c = EXC_BP;
        else if (flags[FLG_TR])      c = EXC_TR;
        else if (flags[FLG_OV])      c = EXC_OV;
        else if (flags[FLG_ADEL_D])  c = EXC_ADEL_D;
        else if (flags[FLG_ADES])    c = EXC_ADES;
        else if (flags[FLG_ERET])    c = EXC_ERET;
        return c;
    endfunction

endpackage

// File: rtl/except_ctrl_int_sync.sv
// Two-flop synchroniser for the six external interrupt lines.
// Latency 2 cycles; no backpressure (free-running).
module int_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] din,
    output logic [5:0] dout
);

    logic [5:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 6'h0;
            dout <= 6'h0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/except_ctrl.sv
// Exception/interrupt controller: prioritise MEM-stage exceptions, report to CP0, flush, redirect PC.
// Latency: code at N+1, flush N+1..N+FLUSH_CYCLES, redirect N+FLUSH_CYCLES+1; stall_i defers acceptance.
// EXC_INT_SYNC_EN selects a two-flop interrupt synchroniser instead of a combinational pass-through.
module except_ctrl
    import except_ctrl_pkg::*;
#(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] HANDLER_OFS  = 32'h180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic        stall_i,
    input  logic [8:0]  exc_flags_i,
    input  logic [31:0] inst_addr_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic [31:0] ebase_i,
    input  logic [5:0]  hw_int_i,
    output logic [5:0]  int_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] badvaddr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        new_pc_valid_o
);

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t      state, state_nxt;
    logic [2:0]  cnt;
    logic        int_pend;
    logic        accept;
    logic [31:0] code;
    logic [31:0] target;
    logic [31:0] badv;

    assign int_pend = (|(cause_i[15:8] & status_i[15:8])) && status_i[0] && !status_i[1];
    assign code     = exc_code(int_pend, exc_flags_i);
    assign accept   = (state == ST_IDLE) && inst_valid_i && !stall_i
                      && (int_pend || (|exc_flags_i));
    assign target   = (code == EXC_ERET) ? epc_i
                                         : ({ebase_i[31:12], 12'h000} + HANDLER_OFS);

    always_comb begin
        badv = 32'h0;
        if (code == EXC_ADEL_I)
            badv = inst_addr_i;
        else if (code == EXC_ADEL_D || code == EXC_ADES)
            badv = mem_addr_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:     if (accept) state_nxt = ST_FLUSH;
            ST_FLUSH:    if (cnt == 3'd0) state_nxt = ST_REDIRECT;
            ST_REDIRECT: state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        flush_o        = (state == ST_FLUSH);
        new_pc_valid_o = (state == ST_REDIRECT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= 3'd0;
        else if (accept)
            cnt <= CNT_INIT;
        else if (state == ST_FLUSH && cnt != 3'd0)
            cnt <= cnt - 3'd1;
    end

    // Context outputs are single-cycle pulses; the redirect target persists until the next acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            excepttype_o        <= 32'h0;
            current_inst_addr_o <= 32'h0;
            is_in_delayslot_o   <= 1'b0;
            badvaddr_o          <= 32'h0;
            new_pc_o            <= 32'h0;
        end else begin
            excepttype_o        <= accept ? code : 32'h0;
            current_inst_addr_o <= accept ? inst_addr_i : 32'h0;
            is_in_delayslot_o   <= accept ? in_delayslot_i : 1'b0;
            badvaddr_o          <= accept ? badv : 32'h0;
            if (accept)
                new_pc_o <= target;
        end
    end

`ifdef EXC_INT_SYNC_EN
    int_sync u_int_sync (
        .clk   (clk),
        .rst_n (rst),
        .din   (hw_int_i),
        .dout  (int_o)
    );
`else
    assign int_o = hw_int_i;
`endif

endmodule

// File: tb/tb_except_ctrl.sv
// Scoreboard bench for except_ctrl: directed test-plan cases then randomized traffic vs a reference model.
module tb_except_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_valid_i = 1'b0;
    logic        stall_i = 1'b0;
    logic [8:0]  exc_flags_i = '0;
    logic [31:0] inst_addr_i = '0;
    logic        in_delayslot_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] status_i = '0;
    logic [31:0] cause_i = '0;
    logic [31:0] epc_i = '0;
    logic [31:0] ebase_i = '0;
    logic [5:0]  hw_int_i = '0;
    logic [5:0]  int_o;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic [31:0] badvaddr_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        new_pc_valid_o;

    except_ctrl #(.FLUSH_CYCLES(FC), .HANDLER_OFS(32'h180)) dut (
        .clk(clk), .rst(rst), .inst_valid_i(inst_valid_i), .stall_i(stall_i),
        .exc_flags_i(exc_flags_i), .inst_addr_i(inst_addr_i), .in_delayslot_i(in_delayslot_i),
        .mem_addr_i(mem_addr_i), .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
        .ebase_i(ebase_i), .hw_int_i(hw_int_i), .int_o(int_o), .excepttype_o(excepttype_o),
        .current_inst_addr_o(current_inst_addr_o), .is_in_delayslot_o(is_in_delayslot_o),
        .badvaddr_o(badvaddr_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
        .new_pc_valid_o(new_pc_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] code;
        logic [31:0] addr;
        logic        ds;
        logic [31:0] badv;
    } exc_t;

    exc_t        exc_q[$];
    logic [31:0] pc_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          free_at = 0;
    logic [5:0]  sync_model = '0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: priority table walked in order, winner defines code and fault address.
    function automatic exc_t ref_exc(input logic pend, input logic [8:0] f, input logic [31:0] ia,
                                     input logic ds, input logic [31:0] ma);
        logic [31:0] codes [9];
        exc_t r;
        codes = '{32'h10, 32'h0a, 32'h08, 32'h0f, 32'h0d, 32'h0c, 32'h11, 32'h12, 32'h0e};
        r.code = 0;
        r.addr = ia;
        r.ds   = ds;
        r.badv = 0;
        if (pend) r.code = 32'h01;
        else begin
            for (int i = 0; i < 9; i++) begin
                if (f[i]) begin
                    r.code = codes[i];
                    break;
                end
            end
        end
        if (r.code == 32'h10) r.badv = ia;
        if (r.code == 32'h11 || r.code == 32'h12) r.badv = ma;
        return r;
    endfunction

    task automatic step(input logic v, input logic st, input logic [8:0] f, input logic [31:0] ia,
                        input logic ds, input logic [31:0] ma, input logic [31:0] stat,
                        input logic [31:0] cs, input logic [31:0] epc, input logic [31:0] eb,
                        input logic [5:0] hw);
        logic pend;
        logic [5:0] exp_int;
        exc_t e;
        @(negedge clk);
        inst_valid_i = v; stall_i = st; exc_flags_i = f; inst_addr_i = ia;
        in_delayslot_i = ds; mem_addr_i = ma; status_i = stat; cause_i = cs;
        epc_i = epc; ebase_i = eb; hw_int_i = hw;
        pend = ((cs[15:8] & stat[15:8]) != 8'h0) && stat[0] && !stat[1];
        if (cyc >= free_at && v && !st && (pend || f != 9'h0)) begin
            e = ref_exc(pend, f, ia, ds, ma);
            exc_q.push_back(e);
            pc_q.push_back(e.code == 32'h0e ? epc : ((eb & 32'hFFFF_F000) + 32'h180));
            free_at = cyc + FC + 2;
        end
        @(posedge clk);
`ifdef EXC_INT_SYNC_EN
        exp_int = sync_model;
        sync_model = hw;
`else
        exp_int = hw;
`endif
        #1 check("int_o", {26'h0, int_o}, {26'h0, exp_int});
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 9'h0, 0, 0, 0, 32'h1, 0, 0, 32'h8000_0000, hw_int_i);
    endtask

    // Monitor: pops expected records whenever the DUT presents a code or a redirect.
    int run = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                run = 0;
            end else begin
                if (excepttype_o != 0) begin
                    if (exc_q.size() == 0) begin
                        check("unexpected_exc", excepttype_o, 32'h0);
                    end else begin
                        exc_t e;
                        e = exc_q.pop_front();
                        check("excepttype", excepttype_o, e.code);
                        check("cur_addr", current_inst_addr_o, e.addr);
                        check("delayslot", {31'h0, is_in_delayslot_o}, {31'h0, e.ds});
                        check("badvaddr", badvaddr_o, e.badv);
                        check("flush_with_exc", {31'h0, flush_o}, 32'h1);
                    end
                end else begin
                    check("idle_ctx", current_inst_addr_o | badvaddr_o, 32'h0);
                end
                if (flush_o) run++;
                else if (run != 0) begin
                    check("flush_len", run, FC);
                    run = 0;
                end
                if (new_pc_valid_o) begin
                    if (pc_q.size() == 0) check("unexpected_redirect", 32'h1, 32'h0);
                    else check("new_pc", new_pc_o, pc_q.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        check("reset_exc", excepttype_o, 32'h0);
        check("reset_flush", {31'h0, flush_o}, 32'h0);
        check("reset_pc", new_pc_o, 32'h0);

        // Syscall
        step(1, 0, 9'h004, 32'hBFC0_0100, 0, 0, 32'h1, 0, 0, 32'h8000_0000, 0);
        idle(5);
        // Priority collision RI|OV|AdES
        step(1, 0, 9'h0A2, 32'h8000_0040, 1, 32'h1234_5678, 32'h1, 0, 0, 32'h8000_0000, 0);
        idle(5);
        // Interrupt accepted / gated by EXL
        step(1, 0, 9'h0, 32'h8000_0080, 0, 0, 32'h0000_0401, 32'h0000_0400, 0, 32'h8000_0000, 0);
        idle(5);
        step(1, 0, 9'h0, 32'h8000_0084, 0, 0, 32'h0000_0403, 32'h0000_0400, 0, 32'h8000_0000, 0);
        idle(3);
        // ERET
        step(1, 0, 9'h100, 32'h8000_0090, 0, 0, 32'h1, 0, 32'h8000_1234, 32'h8000_0000, 0);
        idle(5);
        // AdEL fetch and AdES addresses
        step(1, 0, 9'h001, 32'h8000_0003, 0, 32'hdead_beef, 32'h1, 0, 0, 32'h9000_0abc, 0);
        idle(5);
        step(1, 0, 9'h080, 32'h8000_00a0, 0, 32'h0000_0101, 32'h1, 0, 0, 32'hFFFF_F000, 0);
        idle(5);
        // Stall then release; overflow during FLUSH ignored
        step(1, 1, 9'h004, 32'h8000_00b0, 0, 0, 32'h1, 0, 0, 32'h8000_0000, 0);
        step(1, 1, 9'h004, 32'h8000_00b0, 0, 0, 32'h1, 0, 0, 32'h8000_0000, 0);
        step(1, 0, 9'h004, 32'h8000_00b0, 0, 0, 32'h1, 0, 0, 32'h8000_0000, 0);
        step(1, 0, 9'h020, 32'h8000_00b4, 0, 0, 32'h1, 0, 0, 32'h8000_0000, 0);
        step(1, 0, 9'h020, 32'h8000_00b8, 0, 0, 32'h1, 0, 0, 32'h8000_0000, 0);
        idle(4);

        // Reset in the middle of FLUSH
        step(1, 0, 9'h004, 32'h8000_00c0, 0, 0, 32'h1, 0, 0, 32'h8000_0000, 6'h00);
        inst_valid_i = 1'b0;
        exc_flags_i = 9'h0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_exc", excepttype_o, 32'h0);
        check("rst_mid_flush", {31'h0, flush_o}, 32'h0);
        check("rst_mid_pcv", {31'h0, new_pc_valid_o}, 32'h0);
        check("rst_mid_pc", new_pc_o, 32'h0);
        check("rst_mid_int", {26'h0, int_o}, {26'h0, hw_int_i});
        pc_q.delete();
        sync_model = '0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        free_at = 0;
        step(1, 0, 9'h008, 32'h8000_00d0, 1, 0, 32'h1, 0, 0, 32'h8000_0000, 6'h04);
        idle(6);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] stat, cs;
            logic [8:0]  f;
            stat = {16'h0, 8'($urandom), 6'h0, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 8)};
            cs   = ($urandom_range(0, 5) == 0) ? {16'h0, 8'($urandom), 8'h0} : 32'h0;
            f    = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'h0;
            step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2, f, $urandom, 1'($urandom),
                 $urandom, stat, cs, $urandom, $urandom, 6'($urandom));
        end
        idle(8);
        check("exc_q_drained", exc_q.size(), 0);
        check("pc_q_drained", pc_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
